// File: rtl/z16_instr_loader.sv
`default_nettype none
// ============================================================================
// z16_instr_loader : framed byte stream -> Z16 instruction RAM writer that
//                    holds the core in reset until a verified load completes
// Rev 1.0
// ============================================================================
module z16_instr_loader #(
  parameter int         DEPTH   = 33,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_we,
  output logic [15:0] o_waddr,
  output logic [15:0] o_wdata,
  output logic        o_cpu_rst_n,
  output logic        o_done,
  output logic        o_err
);

  localparam int            IW         = $clog2(DEPTH + 1);
  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] c_idx_one  = IW'(1);
  localparam logic [TW-1:0] c_tmo_one  = TW'(1);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_LO, S_HI, S_WR, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t        r_state, w_next;
  logic [IW-1:0] r_len, r_idx;
  logic [7:0]    r_lo, r_sum;
  logic [TW-1:0] r_tcnt;
  logic          w_accept, w_timed, w_timeout, w_len_bad;

  assign w_accept  = i_byte_valid && o_byte_ready;
  assign w_timed   = (r_state == S_LEN) || (r_state == S_LO) ||
                     (r_state == S_HI)  || (r_state == S_CHK);
  assign w_timeout = w_timed && !w_accept && (r_tcnt == c_tmo_last);
  assign w_len_bad = (i_byte == 8'd0) || ({24'd0, i_byte} > 32'(DEPTH));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_accept && i_byte == SYNC) w_next = S_LEN;
      S_LEN: if (w_accept) w_next = w_len_bad ? S_ERR : S_LO;
      S_LO:  if (w_accept) w_next = S_HI;
      S_HI:  if (w_accept) w_next = S_WR;
      S_WR:  w_next = ((r_idx + c_idx_one) == r_len) ? S_CHK : S_LO;
      S_CHK: if (w_accept) w_next = (i_byte == r_sum) ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
    // Timeout only fires on a cycle with no accepted byte, so it never races a transition.
    if (w_timeout) w_next = S_ERR;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_idx        <= '0;
      r_lo         <= '0;
      r_sum        <= '0;
      r_tcnt       <= '0;
      o_byte_ready <= 1'b1;
      o_we         <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_cpu_rst_n  <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_tcnt       <= (w_timed && !w_accept) ? r_tcnt + c_tmo_one : '0;
      o_we         <= (w_next == S_WR);
      o_byte_ready <= (w_next != S_WR);

      if (w_accept) begin
        case (r_state)
          S_LEN: r_len <= IW'(i_byte);
          S_LO: begin
            r_lo  <= i_byte;
            r_sum <= r_sum + i_byte;
          end
          S_HI: begin
            r_sum   <= r_sum + i_byte;
            o_waddr <= 16'({r_idx, 1'b0});
            o_wdata <= {i_byte, r_lo};
          end
          default: ;
        endcase
      end

      if (r_state == S_WR) r_idx <= r_idx + c_idx_one;

      // Status outputs update only on the edge that enters the new state.
      if (w_next != r_state) begin
        case (w_next)
          S_LEN: begin
            o_cpu_rst_n <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
          end
          S_DONE: begin
            o_done      <= 1'b1;
            o_cpu_rst_n <= 1'b1;
          end
          S_ERR: begin
            o_err       <= 1'b1;
            o_done      <= 1'b0;
            o_cpu_rst_n <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_z16_instr_loader.sv
`default_nettype none
// ============================================================================
// tb_z16_instr_loader : table-driven frames with a write scoreboard
// Rev 1.0
// ============================================================================
module tb_z16_instr_loader;

  localparam int DEPTH   = 33;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready, o_we, o_cpu_rst_n, o_done, o_err;
  logic [15:0] o_waddr, o_wdata;

  always #5 clk = ~clk;

  z16_instr_loader #(.DEPTH(DEPTH), .SYNC(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_byte      (i_byte),
    .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready),
    .o_we        (o_we),
    .o_waddr     (o_waddr),
    .o_wdata     (o_wdata),
    .o_cpu_rst_n (o_cpu_rst_n),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  typedef struct packed {
    logic [127:0] b;     // first byte is the most significant of the n used
    int           n;
    int           nw;
    logic [31:0]  w0;    // {addr, data}
    logic [31:0]  w1;
    logic         done;
    logic         err;
  } vec_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          stalls = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  vec_t        tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got %h expected none", {o_waddr, o_wdata});
      end else begin
        mon_e = exp_q.pop_front();
        chk("write", {o_waddr, o_wdata}, mon_e);
      end
      chk("ready_in_wr", 32'(o_byte_ready), 32'd0);
    end
  end

  task automatic send(input logic [7:0] b);
    logic r;
    r = 1'b0;
    i_byte       = b;
    i_byte_valid = 1'b1;
    for (int t = 0; t < 4 && !r; t++) begin
      @(negedge clk);
      r = o_byte_ready;
      if (!r) stalls++;
      @(posedge clk);
      #1;
    end
    i_byte_valid = 1'b0;
    if (!r) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake: byte %h not accepted, expected acceptance", b);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(o_byte_ready), 32'd1);
    chk({tag, "_we"},    32'(o_we),         32'd0);
    chk({tag, "_waddr"}, 32'(o_waddr),      32'd0);
    chk({tag, "_wdata"}, 32'(o_wdata),      32'd0);
    chk({tag, "_cpu"},   32'(o_cpu_rst_n),  32'd0);
    chk({tag, "_done"},  32'(o_done),       32'd0);
    chk({tag, "_err"},   32'(o_err),        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] bb;
    logic [7:0]   sum, lo, hi;

    tbl[0] = '{b:128'hA5_02_10_00_19_01_2A, n:7, nw:2, w0:32'h0000_0010, w1:32'h0002_0119, done:1'b1, err:1'b0};
    tbl[1] = '{b:128'hA5_01_40_00_41,       n:5, nw:1, w0:32'h0000_0040, w1:32'h0,           done:1'b0, err:1'b1};
    tbl[2] = '{b:128'hA5_00,                n:2, nw:0, w0:32'h0,         w1:32'h0,           done:1'b0, err:1'b1};
    tbl[3] = '{b:128'hA5_22,                n:2, nw:0, w0:32'h0,         w1:32'h0,           done:1'b0, err:1'b1};
    tbl[4] = '{b:128'hA5_01_FD_00_FD,       n:5, nw:1, w0:32'h0000_00FD, w1:32'h0,           done:1'b1, err:1'b0};
    tbl[5] = '{b:128'h00_FF_A5_01_A5_A5_4A, n:7, nw:1, w0:32'h0000_A5A5, w1:32'h0,           done:1'b1, err:1'b0};
    tbl[6] = '{b:128'h00,                   n:1, nw:0, w0:32'h0,         w1:32'h0,           done:1'b1, err:1'b0};

    rst_n        = 1'b0;
    i_byte       = 8'h00;
    i_byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table of whole frames, valid held high across each frame.
    for (int i = 0; i < 7; i++) begin
      stalls = 0;
      bb = tbl[i].b;
      if (tbl[i].nw > 0) exp_q.push_back(tbl[i].w0);
      if (tbl[i].nw > 1) exp_q.push_back(tbl[i].w1);
      for (int k = 0; k < tbl[i].n; k++) send(bb[8*(tbl[i].n-1-k) +: 8]);
      chk($sformatf("v%0d_done", i),   32'(o_done),      32'(tbl[i].done));
      chk($sformatf("v%0d_err", i),    32'(o_err),       32'(tbl[i].err));
      chk($sformatf("v%0d_cpu", i),    32'(o_cpu_rst_n), 32'(tbl[i].done));
      chk($sformatf("v%0d_stalls", i), 32'(stalls),      32'(tbl[i].nw));
      chk($sformatf("v%0d_q_empty", i), 32'(exp_q.size()), 32'd0);
    end

    // Maximum-length frame with random payload.
    stalls = 0;
    sum = 8'h00;
    send(8'hA5);
    send(8'(DEPTH));
    for (int w = 0; w < DEPTH; w++) begin
      lo = 8'($urandom);
      hi = 8'($urandom);
      exp_q.push_back({16'(w * 2), hi, lo});
      sum = sum + lo + hi;
      send(lo);
      send(hi);
    end
    send(sum);
    chk("max_done",   32'(o_done),       32'd1);
    chk("max_stalls", 32'(stalls),       32'(DEPTH));
    chk("max_q",      32'(exp_q.size()), 32'd0);

    // Timeout: stall in HI.
    send(8'hA5);
    send(8'h01);
    send(8'h10);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    chk("tmo_early_err", 32'(o_err), 32'd0);
    @(posedge clk);
    #1;
    chk("tmo_err", 32'(o_err),       32'd1);
    chk("tmo_cpu", 32'(o_cpu_rst_n), 32'd0);

    // Asynchronous reset mid-frame, between clock edges.
    exp_q.push_back(32'h0000_0010);
    exp_q.push_back(32'h0002_0020);
    send(8'hA5); send(8'h03); send(8'h10); send(8'h00); send(8'h20); send(8'h00);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    chk("async_q", 32'(exp_q.size()), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0000_0010);
    exp_q.push_back(32'h0002_0119);
    send(8'hA5); send(8'h02); send(8'h10); send(8'h00); send(8'h19); send(8'h01); send(8'h2A);
    chk("post_rst_done", 32'(o_done),       32'd1);
    chk("post_rst_cpu",  32'(o_cpu_rst_n),  32'd1);
    chk("post_rst_q",    32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
